// File: rtl/status_display.sv
// Seven-segment status display for the password FSM: blank / progress dashes / blinking "Err" / "OPEn".
// Define STATUS_DISPLAY_COUNT_EN to add saturating error/success counters on HEX5/HEX4.
module status_display #(
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst_a_p,
    input  logic [1:0] disp_state,
    input  logic [2:0] disp_debug,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5
);

    localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_R     = 7'b0101111;
    localparam logic [6:0] G_O     = 7'b1000000;
    localparam logic [6:0] G_P     = 7'b0001100;
    localparam logic [6:0] G_N     = 7'b0101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR  = 2'd1,
        ST_DONE = 2'd2,
        ST_PROC = 2'd3
    } st_e;

    st_e             st_q, st_qq;
    logic [2:0]      step_q;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_eff;
    logic            phase_q, phase_d, phase_eff;
    logic            err_evt;
    logic [3:0]      dash_mask;
    logic [3:0][6:0] low_q, low_d;

    assign err_evt = (st_q == ST_ERR) && (st_qq != ST_ERR);

    // Every error entry restarts the blink from the visible phase.
    always_comb begin
        cnt_eff   = err_evt ? '0 : cnt_q;
        phase_eff = err_evt ? 1'b1 : phase_q;
        cnt_d     = '0;
        phase_d   = 1'b1;
        if (st_q == ST_ERR) begin
            if (cnt_eff == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_eff;
            end else begin
                cnt_d   = cnt_eff + 1'b1;
                phase_d = phase_eff;
            end
        end
    end

    always_comb begin
        low_d = {4{G_BLANK}};
        case (step_q)
            3'd3:    dash_mask = 4'b1100;
            3'd4:    dash_mask = 4'b1110;
            default: dash_mask = 4'b1000;
        endcase
        case (st_q)
            ST_PROC: begin
                for (int i = 0; i < 4; i++)
                    if (dash_mask[i]) low_d[i] = G_DASH;
            end
            ST_ERR: begin
                if (phase_eff) low_d = {G_E, G_R, G_R, G_BLANK};
            end
            ST_DONE: low_d = {G_O, G_P, G_E, G_N};
            default: low_d = {4{G_BLANK}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            st_q    <= ST_IDLE;
            st_qq   <= ST_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            low_q   <= {4{G_BLANK}};
        end else begin
            st_q    <= st_e'(disp_state);
            st_qq   <= st_q;
            step_q  <= disp_debug;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            low_q   <= low_d;
        end
    end

    assign hex0 = low_q[0];
    assign hex1 = low_q[1];
    assign hex2 = low_q[2];
    assign hex3 = low_q[3];

`ifdef STATUS_DISPLAY_COUNT_EN
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 7'b1000000;
            4'd1:    seg_digit = 7'b1111001;
            4'd2:    seg_digit = 7'b0100100;
            4'd3:    seg_digit = 7'b0110000;
            4'd4:    seg_digit = 7'b0011001;
            4'd5:    seg_digit = 7'b0010010;
            4'd6:    seg_digit = 7'b0000010;
            4'd7:    seg_digit = 7'b1111000;
            4'd8:    seg_digit = 7'b0000000;
            4'd9:    seg_digit = 7'b0010000;
            default: seg_digit = G_BLANK;
        endcase
    endfunction

    logic            ok_evt;
    logic [3:0]      err_cnt_q, err_cnt_d, ok_cnt_q, ok_cnt_d;
    logic [1:0][6:0] hi_q;

    assign ok_evt = (st_q == ST_DONE) && (st_qq != ST_DONE);

    always_comb begin
        err_cnt_d = err_cnt_q;
        ok_cnt_d  = ok_cnt_q;
        if (err_evt && err_cnt_q != 4'd9) err_cnt_d = err_cnt_q + 4'd1;
        if (ok_evt  && ok_cnt_q  != 4'd9) ok_cnt_d  = ok_cnt_q  + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            err_cnt_q <= '0;
            ok_cnt_q  <= '0;
            hi_q      <= {G_BLANK, G_BLANK};
        end else begin
            err_cnt_q <= err_cnt_d;
            ok_cnt_q  <= ok_cnt_d;
            hi_q      <= {seg_digit(err_cnt_q), seg_digit(ok_cnt_q)};
        end
    end

    assign hex5 = hi_q[1];
    assign hex4 = hi_q[0];
`else
    assign hex5 = G_BLANK;
    assign hex4 = G_BLANK;
`endif

endmodule
